// File: rtl/sig_control_param.sv
// Highway/country-road traffic signal controller with counter-timed phases.
// Optional night flashing mode is enabled by defining FLASH_MODE_EN.
module sig_control_param #(
    parameter int CW        = 4,
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int MIN_HG    = 4,
    parameter int MAX_CG    = 8
`ifdef FLASH_MODE_EN
    ,
    parameter int FLASH_HALF = 2
`endif
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
`ifdef FLASH_MODE_EN
    input  logic       night,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state_o
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] OFF    = 2'd3;

    localparam logic [CW-1:0] HG_LAST = CW'(MIN_HG - 1);
    localparam logic [CW-1:0] YR_LAST = CW'(Y2R_DELAY - 1);
    localparam logic [CW-1:0] RG_LAST = CW'(R2G_DELAY - 1);
    localparam logic [CW-1:0] CG_LAST = CW'(MAX_CG - 1);

    logic [2:0]    state;
    logic [2:0]    next;
    logic [CW-1:0] timer;
`ifdef FLASH_MODE_EN
    localparam logic [CW-1:0] FL_LAST = CW'(FLASH_HALF - 1);
    logic          blink;
`endif

    always_comb begin
        next = S0;
        case (state)
            S0: begin
                next = S0;
`ifdef FLASH_MODE_EN
                if (night)
                    next = S5;
                else
`endif
                if (x && timer >= HG_LAST)
                    next = S1;
            end
            S1: next = (timer == YR_LAST) ? S2 : S1;
            S2: next = (timer == RG_LAST) ? S3 : S2;
            S3: next = (!x || timer == CG_LAST) ? S4 : S3;
            S4: next = (timer == YR_LAST) ? S0 : S4;
`ifdef FLASH_MODE_EN
            S5: next = night ? S5 : S0;
`endif
            default: next = S0;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S0;
            timer <= '0;
`ifdef FLASH_MODE_EN
            blink <= 1'b0;
`endif
        end else begin
            state <= next;
            if (next != state) begin
                timer <= '0;
`ifdef FLASH_MODE_EN
                blink <= 1'b0;
            end else if (state == S5 && timer == FL_LAST) begin
                // timer doubles as the blink half-period counter in S5
                timer <= '0;
                blink <= ~blink;
`endif
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        hwy   = RED;
        cntry = RED;
        case (state)
            S0: begin hwy = GREEN;  cntry = RED;    end
            S1: begin hwy = YELLOW; cntry = RED;    end
            S2: begin hwy = RED;    cntry = RED;    end
            S3: begin hwy = RED;    cntry = GREEN;  end
            S4: begin hwy = RED;    cntry = YELLOW; end
`ifdef FLASH_MODE_EN
            S5: begin
                hwy   = blink ? YELLOW : OFF;
                cntry = blink ? RED : OFF;
            end
`endif
            default: begin hwy = RED; cntry = RED; end
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_sig_control_param.sv
// Scoreboard bench for sig_control_param with default parameters.
// Define FLASH_MODE_EN to also exercise the night flashing mode.
module tb_sig_control_param;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       x = 1'b0;
`ifdef FLASH_MODE_EN
    logic       night = 1'b0;
`endif
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] state_o;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] h;
        logic [1:0] c;
    } exp_t;

    exp_t sb[$];

    sig_control_param dut (
        .clk(clk),
        .clear(clear),
        .x(x),
`ifdef FLASH_MODE_EN
        .night(night),
`endif
        .hwy(hwy),
        .cntry(cntry),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st = st;
        case (st)
            3'd0: begin e.h = 2'd2; e.c = 2'd0; end
            3'd1: begin e.h = 2'd1; e.c = 2'd0; end
            3'd2: begin e.h = 2'd0; e.c = 2'd0; end
            3'd3: begin e.h = 2'd0; e.c = 2'd2; end
            default: begin e.h = 2'd0; e.c = 2'd1; end
        endcase
        return e;
    endfunction

    task automatic tick(input logic xv, input exp_t e);
        x = xv;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        clear = 1'b1;
        x = 1'b1;
        sb.push_back(mk(3'd0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compared++;
        if ({state_o, hwy, cntry} !== e) begin
            mismatched++;
            $display("FAIL reset_hold: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                     state_o, hwy, cntry, e.st, e.h, e.c);
        end
    endtask

    task automatic test_min_green;
        logic [2:0] sts [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 3};
        exp_t e;
        clear = 1'b0;
        x = 1'b1;
        sb.push_back(mk(3'd0));
        e = sb.pop_front();
        compared++;
        if ({state_o, hwy, cntry} !== e) begin
            mismatched++;
            $display("FAIL min_green release: got st=%0d want st=%0d", state_o, e.st);
        end
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, mk(sts[i]));
            e = sb.pop_front();
            compared++;
            if ({state_o, hwy, cntry} !== e) begin
                mismatched++;
                $display("FAIL min_green[%0d]: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                         i, state_o, hwy, cntry, e.st, e.h, e.c);
            end
        end
    endtask

    task automatic test_max_green;
        logic [2:0] sts [15] = '{3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 0, 0, 0, 0, 1};
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, mk(sts[i]));
            e = sb.pop_front();
            compared++;
            if ({state_o, hwy, cntry} !== e) begin
                mismatched++;
                $display("FAIL max_green[%0d]: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                         i, state_o, hwy, cntry, e.st, e.h, e.c);
            end
        end
    endtask

    task automatic test_demand_end;
        logic [2:0] sts [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 0};
        logic       xs  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            tick(xs[i], mk(sts[i]));
            e = sb.pop_front();
            compared++;
            if ({state_o, hwy, cntry} !== e) begin
                mismatched++;
                $display("FAIL demand_end[%0d]: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                         i, state_o, hwy, cntry, e.st, e.h, e.c);
            end
        end
    endtask

    task automatic test_yellow_commit;
        logic [2:0] sts [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 4, 4, 0};
        logic       xs  [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            tick(xs[i], mk(sts[i]));
            e = sb.pop_front();
            compared++;
            if ({state_o, hwy, cntry} !== e) begin
                mismatched++;
                $display("FAIL yellow_commit[%0d]: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                         i, state_o, hwy, cntry, e.st, e.h, e.c);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] sts [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 3};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, mk(sts[i]));
            e = sb.pop_front();
            compared++;
            if ({state_o, hwy, cntry} !== e) begin
                mismatched++;
                $display("FAIL reset_mid_setup[%0d]: got st=%0d want st=%0d",
                         i, state_o, e.st);
            end
        end
        #3;
        clear = 1'b1;
        sb.push_back(mk(3'd0));
        #1;
        e = sb.pop_front();
        compared++;
        if ({state_o, hwy, cntry} !== e) begin
            mismatched++;
            $display("FAIL reset_mid_async: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                     state_o, hwy, cntry, e.st, e.h, e.c);
        end
        tick(1'b1, mk(3'd0));
        e = sb.pop_front();
        compared++;
        if ({state_o, hwy, cntry} !== e) begin
            mismatched++;
            $display("FAIL reset_mid_held: got st=%0d want st=%0d", state_o, e.st);
        end
        clear = 1'b0;
        x = 1'b0;
    endtask

`ifdef FLASH_MODE_EN
    task automatic test_flash;
        exp_t off_e;
        exp_t yr_e;
        exp_t e;
        exp_t want [7];
        off_e = '{st: 3'd5, h: 2'd3, c: 2'd3};
        yr_e  = '{st: 3'd5, h: 2'd1, c: 2'd0};
        want = '{off_e, off_e, yr_e, yr_e, off_e, off_e, mk(3'd0)};
        night = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6)
                night = 1'b0;
            tick(1'b1, want[i]);
            e = sb.pop_front();
            compared++;
            if ({state_o, hwy, cntry} !== e) begin
                mismatched++;
                $display("FAIL flash[%0d]: got st=%0d h=%0d c=%0d want st=%0d h=%0d c=%0d",
                         i, state_o, hwy, cntry, e.st, e.h, e.c);
            end
        end
        x = 1'b0;
    endtask
`endif

    initial begin
        #2;
        test_reset;
        test_min_green;
        test_max_green;
        test_demand_end;
        test_yellow_commit;
        test_reset_mid;
`ifdef FLASH_MODE_EN
        test_flash;
`endif
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
